scoreboard_stall_unit: RTL and testbench
========================================

# scoreboard_stall_unit

Issue-stage register scoreboard for the SPU pipeline. It tracks in-flight register writes from multi-cycle execution units whose results are not yet reachable by the MEM/WB forwarding paths. It stalls the instruction in ID when one of its source registers (RA_ID, RB_ID) names a pending write. Once a pending result reaches MEM, the entry retires and forwarding takes over.

## Interface
Parameters:
- DEPTH, 8: number of scoreboard entries (max in-flight tracked writes); power of two, 2..16.
- LAT_W, 3: width of the latency field; max latency 2**LAT_W-1.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all entries.
- issue_valid  input  1  instruction present in ID requesting issue.
- issue_RegWrite  input  1  issuing instruction writes a register.
- issue_WriteRegAddress  input  7  destination register of issuing instruction.
- issue_latency  input  LAT_W  cycles from issue until the result is visible at MEM-stage forwarding; 0 = no tracking needed.
- RA_ID  input  7  source register A of instruction in ID.
- RB_ID  input  7  source register B of instruction in ID.
- flush  input  1  pipeline flush; discards all pending entries.
- stall  output  1  hold ID/IF and inject bubble into EX.
- issue_accept  output  1  issue_valid && !stall && !flush.
- InFlight  output  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Each entry holds valid, dest[6:0] and cnt[LAT_W-1:0].
- Hazard: any valid entry with dest == RA_ID or dest == RB_ID. Matching is conservative; multiple entries for the same dest are allowed and all are checked.
- Full: issue_valid && issue_RegWrite && issue_latency != 0 && no free entry.
- stall = issue_valid && (hazard || full); combinational from registered entry state and current inputs.
- Allocate on issue_accept && issue_RegWrite && issue_latency != 0:
  - use the lowest-index free entry;
  - set valid=1, dest=issue_WriteRegAddress, cnt=issue_latency.
- Each cycle, every valid entry decrements cnt. An entry with cnt==1 clears valid on that edge, and its slot is allocatable in the same edge's update only from the next cycle onward.
- Allocation and retirement in the same cycle are independent. InFlight next = InFlight + alloc − retirements.
- Latency 0, or issue_RegWrite=0: no entry, never stalls on full.
- flush: all valid cleared on the edge; any allocation that cycle is suppressed; stall still reflects pre-flush state combinationally.
- Register 0 is not special.

## Timing
- Reset values:
  - all entries valid=0, cnt=0, dest=0;
  - stall=0, issue_accept=issue_valid, InFlight=0.
- Instruction issued at cycle T with latency L creates a hazard on its dest for cycles T+1..T+L. A dependent in ID at cycle T+L+1 proceeds, with the value taken from MEM forwarding.
- Reset asserted mid-operation wins over flush and issue; state is clear after one edge.
- stall has zero cycles of latency from inputs.

## Configuration
- SCOREBOARD_STATS_EN defined:
  - adds output StallCount[15:0], incremented on each cycle with stall=1;
  - saturates at 16'hFFFF;
  - cleared by reset only, not by flush.
- Undefined: the port and its counter are absent.

## Test plan
- Issue dest=7'd5, L=3 at T0; RA_ID=5 in ID T1..T4 -> stall=1 at T1,T2,T3 and stall=0 at T4; InFlight 1 at T1..T3, 0 at T4.
- Issue dest=10, L=2; then an unrelated instruction RA=11/RB=12 -> stall=0, issue_accept=1, InFlight increments to 2.
- DEPTH=8: issue 8 writes, L=7, distinct dests; 9th issue with RegWrite=1, L=4 -> stall=1 (full) until the first entry retires, then accepted the next cycle.
- InFlight=3, then flush=1 with issue_valid=1, L=5 -> InFlight=0 next cycle and no entry allocated; a dependent on the flushed dest is not stalled.
- Two writes to dest=20 with L=2 then L=6 -> RB_ID=20 stalls until the L=6 entry retires.
- With SCOREBOARD_STATS_EN: 4 stall cycles -> StallCount=4; a flush leaves it at 4; reset sets it to 0.

Source files
------------

// File: rtl/scoreboard_stall_unit.sv
//-----------------------------------------------------------------------------
// scoreboard_stall_unit
//
// Issue-stage register scoreboard. It tracks register writes from multi-cycle
// execution units whose results cannot yet be forwarded from MEM/WB. The
// instruction in ID stalls while either source register names a pending
// write. An entry retires once its result reaches MEM, and forwarding covers
// it from then on.
//
// Parameters:
//   DEPTH  number of tracked in-flight writes (power of two, 2..16)
//   LAT_W  width of the latency field (max latency 2**LAT_W-1)
//
// Ports:
//   clk                    pipeline clock, rising edge
//   reset                  synchronous active-high clear of all entries
//   issue_valid            instruction present in ID requesting issue
//   issue_RegWrite         issuing instruction writes a register
//   issue_WriteRegAddress  destination register of the issuing instruction
//   issue_latency          cycles until the result is forwardable (0 = untracked)
//   RA_ID, RB_ID           source registers of the instruction in ID
//   flush                  discard all pending entries
//   stall                  hold ID/IF, bubble into EX (combinational)
//   issue_accept           issue_valid && !stall && !flush
//   InFlight               number of valid entries
//   StallCount             saturating count of stall cycles
//                          (present only when SCOREBOARD_STATS_EN is defined)
//
// Optional feature macro: SCOREBOARD_STATS_EN
//-----------------------------------------------------------------------------
module scoreboard_stall_unit #(
    parameter int DEPTH = 8,
    parameter int LAT_W = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic                     issue_RegWrite,
    input  logic [6:0]               issue_WriteRegAddress,
    input  logic [LAT_W-1:0]         issue_latency,
    input  logic [6:0]               RA_ID,
    input  logic [6:0]               RB_ID,
    input  logic                     flush,
    output logic                     stall,
    output logic                     issue_accept,
    output logic [$clog2(DEPTH):0]   InFlight
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [15:0]              StallCount
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Entry storage
    logic [DEPTH-1:0] validReg;
    logic [6:0]       destReg [DEPTH];
    logic [LAT_W-1:0] cntReg  [DEPTH];

    // Per-entry decode
    logic [DEPTH-1:0] hitVec;
    logic [DEPTH-1:0] freeVec;
    logic [DEPTH-1:0] allocSel;

    logic wantAlloc;
    logic hazard;
    logic full;
    logic doAlloc;

    // Source match against every valid entry. Duplicate destinations are
    // allowed; any one of them still pending is enough to stall.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gHit
            assign hitVec[gi] = validReg[gi] &&
                                ((destReg[gi] == RA_ID) || (destReg[gi] == RB_ID));
        end
    endgenerate

    // A slot retiring this cycle still reads as occupied here; it becomes
    // allocatable only after its valid bit has actually cleared.
    assign freeVec  = ~validReg;

    // Isolate the lowest set bit: lowest-index free entry as a one-hot.
    assign allocSel = freeVec & (~freeVec + DEPTH'(1));

    assign wantAlloc    = issue_valid && issue_RegWrite && (issue_latency != '0);
    assign hazard       = |hitVec;
    assign full         = wantAlloc && !(|freeVec);
    assign stall        = issue_valid && (hazard || full);
    assign issue_accept = issue_valid && !stall && !flush;
    assign doAlloc      = issue_accept && issue_RegWrite && (issue_latency != '0);

    // Entry update. Allocation only targets a free slot, so it never collides
    // with the countdown of a valid slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            validReg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                destReg[i] <= '0;
                cntReg[i]  <= '0;
            end
        end else if (flush) begin
            validReg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cntReg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (doAlloc && allocSel[i]) begin
                    validReg[i] <= 1'b1;
                    destReg[i]  <= issue_WriteRegAddress;
                    cntReg[i]   <= issue_latency;
                end else if (validReg[i]) begin
                    cntReg[i] <= cntReg[i] - LAT_W'(1);
                    // Last hazard cycle: the result reaches MEM next cycle.
                    if (cntReg[i] == LAT_W'(1)) begin
                        validReg[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Occupancy is the population count of the valid bits, which tracks
    // previous + allocations - retirements by construction.
    always_comb begin
        InFlight = '0;
        for (int i = 0; i < DEPTH; i++) begin
            InFlight = InFlight + CNT_W'(validReg[i]);
        end
    end

`ifdef SCOREBOARD_STATS_EN
    // Stall statistics: saturating, cleared only by reset (survives flush).
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCount <= '0;
        end else if (stall && (StallCount != 16'hFFFF)) begin
            StallCount <= StallCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_scoreboard_stall_unit.sv
module tb_scoreboard_stall_unit;

    localparam int DEPTH = 8;
    localparam int LAT_W = 4;   // wide enough to keep 8 entries busy at once

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   issue_valid;
    logic                   issue_RegWrite;
    logic [6:0]             issue_WriteRegAddress;
    logic [LAT_W-1:0]       issue_latency;
    logic [6:0]             RA_ID;
    logic [6:0]             RB_ID;
    logic                   flush;
    logic                   stall;
    logic                   issue_accept;
    logic [$clog2(DEPTH):0] InFlight;
`ifdef SCOREBOARD_STATS_EN
    logic [15:0]            StallCount;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scoreboard_stall_unit #(.DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .issue_valid           (issue_valid),
        .issue_RegWrite        (issue_RegWrite),
        .issue_WriteRegAddress (issue_WriteRegAddress),
        .issue_latency         (issue_latency),
        .RA_ID                 (RA_ID),
        .RB_ID                 (RB_ID),
        .flush                 (flush),
        .stall                 (stall),
        .issue_accept          (issue_accept),
        .InFlight              (InFlight)
`ifdef SCOREBOARD_STATS_EN
        ,
        .StallCount            (StallCount)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One pipeline cycle: inputs change at the falling edge and are checked
    // 1 time unit later; the following rising edge commits them.
    task automatic cyc(input logic v, input logic rw, input logic [6:0] d,
                       input logic [LAT_W-1:0] l, input logic [6:0] ra,
                       input logic [6:0] rb, input logic fl, input logic rs);
        @(negedge clk);
        issue_valid           = v;
        issue_RegWrite        = rw;
        issue_WriteRegAddress = d;
        issue_latency         = l;
        RA_ID                 = ra;
        RB_ID                 = rb;
        flush                 = fl;
        reset                 = rs;
        #1;
        $display("t=%0t v=%0b rw=%0b d=%0d L=%0d ra=%0d rb=%0d fl=%0b rs=%0b -> stall=%0b acc=%0b inflight=%0d",
                 $time, v, rw, d, l, ra, rb, fl, rs, stall, issue_accept, InFlight);
    endtask

    initial begin
        reset = 1'b1; issue_valid = 1'b0; issue_RegWrite = 1'b0;
        issue_WriteRegAddress = '0; issue_latency = '0;
        RA_ID = '0; RB_ID = '0; flush = 1'b0;

        // Reset state
        cyc(1, 1, 7'd9, 4'd3, 0, 0, 0, 1);
        cyc(1, 1, 7'd9, 4'd3, 0, 0, 0, 1);
        check("reset_stall", 32'(stall), 0);
        check("reset_accept", 32'(issue_accept), 1);
        check("reset_inflight", 32'(InFlight), 0);

        // dest 5, L=3: hazard for exactly three cycles
        cyc(1, 1, 7'd5, 4'd3, 0, 0, 0, 0);
        check("t0_accept", 32'(issue_accept), 1);
        check("t0_inflight", 32'(InFlight), 0);
        for (int k = 1; k <= 3; k++) begin
            cyc(1, 0, 0, 0, 7'd5, 0, 0, 0);
            check("lat3_stall", 32'(stall), 1);
            check("lat3_accept", 32'(issue_accept), 0);
            check("lat3_inflight", 32'(InFlight), 1);
        end
        cyc(1, 0, 0, 0, 7'd5, 0, 0, 0);
        check("lat3_release_stall", 32'(stall), 0);
        check("lat3_release_accept", 32'(issue_accept), 1);
        check("lat3_release_inflight", 32'(InFlight), 0);

        // Unrelated instruction proceeds while dest 10 is pending
        cyc(1, 1, 7'd10, 4'd2, 0, 0, 0, 0);
        check("d10_accept", 32'(issue_accept), 1);
        cyc(1, 1, 7'd13, 4'd2, 7'd11, 7'd12, 0, 0);
        check("unrel_stall", 32'(stall), 0);
        check("unrel_accept", 32'(issue_accept), 1);
        check("unrel_inflight", 32'(InFlight), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("two_inflight", 32'(InFlight), 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("one_inflight", 32'(InFlight), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("drained_inflight", 32'(InFlight), 0);

        // Two writes to dest 20: stall lasts until the longer one retires
        cyc(1, 1, 7'd20, 4'd2, 0, 0, 0, 0);
        check("w20a_accept", 32'(issue_accept), 1);
        cyc(1, 1, 7'd20, 4'd6, 0, 0, 0, 0);
        check("w20b_accept", 32'(issue_accept), 1);
        check("w20b_inflight", 32'(InFlight), 1);
        cyc(1, 0, 0, 0, 0, 7'd20, 0, 0);
        check("w20_dual_inflight", 32'(InFlight), 2);
        check("w20_stall", 32'(stall), 1);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 0, 0, 0, 0, 7'd20, 0, 0);
            check("w20_stall", 32'(stall), 1);
        end
        cyc(1, 0, 0, 0, 0, 7'd20, 0, 0);
        check("w20_release", 32'(stall), 0);
        check("w20_release_inflight", 32'(InFlight), 0);

        // Flush with three pending entries and a concurrent issue
        cyc(1, 1, 7'd30, 4'd7, 7'd1, 7'd2, 0, 0);
        cyc(1, 1, 7'd31, 4'd7, 7'd1, 7'd2, 0, 0);
        cyc(1, 1, 7'd32, 4'd7, 7'd1, 7'd2, 0, 0);
        check("pre_flush_accept", 32'(issue_accept), 1);
        cyc(1, 1, 7'd33, 4'd5, 7'd30, 7'd2, 1, 0);
        check("flush_inflight_before", 32'(InFlight), 3);
        check("flush_stall_preflush", 32'(stall), 1);
        check("flush_accept", 32'(issue_accept), 0);
        cyc(1, 0, 0, 0, 7'd30, 7'd33, 0, 0);
        check("post_flush_inflight", 32'(InFlight), 0);
        check("post_flush_stall", 32'(stall), 0);
        check("post_flush_accept", 32'(issue_accept), 1);

        // Fill all 8 entries (L=10), then a 9th tracked write
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 7'(40 + i), 4'd10, 0, 0, 0, 0);
            check("fill_accept", 32'(issue_accept), 1);
            check("fill_inflight", 32'(InFlight), 32'(i));
        end
        cyc(1, 1, 7'd48, 4'd4, 7'd100, 7'd101, 0, 0);
        check("full_stall", 32'(stall), 1);
        check("full_accept", 32'(issue_accept), 0);
        check("full_inflight", 32'(InFlight), 8);
        cyc(1, 1, 7'd49, 4'd0, 7'd100, 7'd101, 0, 0);
        check("full_lat0_stall", 32'(stall), 0);
        check("full_lat0_accept", 32'(issue_accept), 1);
        cyc(1, 1, 7'd48, 4'd4, 7'd100, 7'd101, 0, 0);
        check("full_retiring_stall", 32'(stall), 1);
        check("full_retiring_inflight", 32'(InFlight), 8);
        cyc(1, 1, 7'd48, 4'd4, 7'd100, 7'd101, 0, 0);
        check("full_freed_stall", 32'(stall), 0);
        check("full_freed_accept", 32'(issue_accept), 1);
        check("full_freed_inflight", 32'(InFlight), 7);
        cyc(1, 0, 0, 0, 7'd49, 0, 0, 0);
        check("lat0_untracked", 32'(stall), 0);
        check("after_9th_inflight", 32'(InFlight), 7);
        cyc(1, 0, 0, 0, 7'd48, 0, 0, 0);
        check("ninth_hazard", 32'(stall), 1);
        check("ninth_inflight", 32'(InFlight), 6);

        // Reset beats flush and issue
        cyc(1, 1, 7'd50, 4'd5, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 7'd48, 7'd50, 0, 0);
        check("midreset_inflight", 32'(InFlight), 0);
        check("midreset_stall", 32'(stall), 0);
        check("midreset_accept", 32'(issue_accept), 1);

`ifdef SCOREBOARD_STATS_EN
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 7'd60, 4'd4, 0, 0, 0, 0);
        check("stats_reset", 32'(StallCount), 0);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0, 0, 7'd60, 0, 0, 0);
            check("stats_stall", 32'(stall), 1);
        end
        cyc(1, 0, 0, 0, 7'd60, 0, 0, 0);
        check("stats_count4", 32'(StallCount), 4);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("stats_after_flush", 32'(StallCount), 4);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("stats_cleared", 32'(StallCount), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
